posit_decode_arbiter_8bit: RTL
==============================

# posit_decode_arbiter_8bit

Shares one 8-bit posit decoder among NREQ independent requesters. Each requester has its own valid/ready channel. Each cycle, one requester is granted. Its posit goes through a two-stage registered pipeline (capture, then decode), and the 12-bit extended posit comes out tagged with the requester index. The block sits between the posit operand sources (register-file read ports, load unit) and the downstream extended-posit arithmetic units.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i presents a posit.
- req_posit  in  NREQ*8  posit of requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot or zero; handshake on req_valid[i]&req_ready[i].
- out_valid  out  1  out_eposit/out_id are valid.
- out_ready  in  1  consumer accepts the result.
- out_eposit  out  12  {inf, zero, sign, regime[3:0], expfrac[4:0]}.
- out_id  out  IDW  index of the requester that produced the result.
- inflight  out  2  number of occupied pipeline stages (0..2).

## Operation
- Stage S1 holds s1_valid, s1_posit[7:0] and s1_id. Stage S2 holds out_valid, out_eposit and out_id.
- Advance conditions:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
- Arbitration (combinational):
  - Among the requesters with req_valid set, pick a winner g using the priority order given under Configuration.
  - req_ready[g] = s1_adv; all other req_ready bits are 0.
  - req_ready never depends on req_valid[g] being low, and no ready is issued when no valid is present.
- On accept, S1 loads req_posit[g] and id g, and sets s1_valid. If s1_adv is true and there is no request, s1_valid clears.
- On s2_adv with s1_valid set, S2 loads decode(s1_posit) and s1_id, and sets out_valid. If s2_adv is true and s1_valid is clear, out_valid clears.
- Decode is the team's standard 8-bit posit decode:
  - posit 0x00 gives zero=1.
  - posit 0x80 gives inf=1 and sign=1.
  - regime is a 4-bit biased value; 7 means regime 0.
  - expfrac holds the 5 bits that follow the regime terminator, left-aligned.
- Hold rule: while out_valid & ~out_ready, out_eposit and out_id are stable and S1 does not overwrite S2.
- inflight = s1_valid + out_valid.
- The requester side must hold req_posit[i] stable while req_valid[i] & ~req_ready[i]. The block does not check this.

## Timing
- Reset values: s1_valid=0, out_valid=0, out_eposit=12'h000, out_id=0, inflight=0, round-robin pointer=0. req_ready is 0 while rst is asserted.
- Reset asserted mid-operation discards both stages immediately. No output handshake occurs for discarded entries.
- Latency: a request accepted at edge N shows out_valid after edge N+1, when S2 is free.
- Throughput: one result per cycle with out_ready held high.
- Full pipeline: with out_valid=1, s1_valid=1 and out_ready=0, all req_ready bits are 0.
- Simultaneous events:
  - An output handshake and a new accept in the same cycle both happen: S1 moves into S2 and the new request enters S1.
  - All NREQ requesters valid in the same cycle: exactly one is granted.

## Configuration
- POSIT_DEC_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at the pointer ptr.
  - After each accept, ptr becomes (g+1) mod NREQ, wrapping from NREQ-1 to 0.
  - ptr only changes on an accept.
- POSIT_DEC_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists.

## Structure
- Package posit_dec_pkg contains:
  - EPOSIT_W=12.
  - Field index constants: INF=11, ZERO=10, SIGN=9, REGIME 8:5, EXPFRAC 4:0.
  - The REGIME_BIAS=7 constant.
- Sub-module posit_dec_grant: a combinational arbiter with inputs req_valid, ptr and enable, and a one-hot grant output. The RR/fixed choice is made inside it.
- The decode between S1 and S2 instantiates the existing decode_posit_8bit.

## Test plan
- Single requester 0 sends 0x40 with out_ready=1 → out_valid two cycles after accept, out_eposit=12'h0E0, out_id=0.
- Requester 2 sends 0x00, then 0x80 → 12'h400 and 12'hBA0 in order, both with out_id=2, back-to-back.
- RR build, all four requesters valid continuously with out_ready=1 → grant order 0,1,2,3,0,… with one result per cycle. Fixed build → requester 0 always wins.
- Hold out_ready=0 for 5 cycles with traffic → pipeline fills (inflight=2), req_ready=0, out_eposit stable. Release → no loss or duplication.
- Assert rst while inflight=2 → out_valid=0 and inflight=0 immediately. The first post-reset request is granted to index 0.
- Simultaneous out handshake and new accept → inflight stays 2 and results stay in order.

Source files
------------

// File: rtl/posit_dec_pkg.sv
// Shared constants and the extended-posit payload layout for the posit decode arbiter.
package posit_dec_pkg;

  localparam int unsigned POSIT_W     = 8;
  localparam int unsigned EPOSIT_W    = 12;
  localparam int unsigned REGIME_W    = 4;
  localparam int unsigned EXPFRAC_W   = 5;

  localparam int unsigned INF         = 11;
  localparam int unsigned ZERO        = 10;
  localparam int unsigned SIGN        = 9;
  localparam int unsigned REGIME_MSB  = 8;
  localparam int unsigned REGIME_LSB  = 5;
  localparam int unsigned EXPFRAC_MSB = 4;
  localparam int unsigned EXPFRAC_LSB = 0;

  localparam int unsigned REGIME_BIAS = 7;

  typedef struct packed {
    logic                 inf;
    logic                 zero;
    logic                 sign;
    logic [REGIME_W-1:0]  regime;
    logic [EXPFRAC_W-1:0] expfrac;
  } eposit_t;

endpackage

// File: rtl/decode_posit_8bit.sv
// Combinational 8-bit posit decode into the 12-bit extended-posit layout.
module decode_posit_8bit
  import posit_dec_pkg::*;
(
  input  logic [POSIT_W-1:0]  posit_i,
  output logic [EPOSIT_W-1:0] eposit_c
);

  logic [6:0] body;
  logic [6:0] tail;
  logic [3:0] run_len;
  logic       run_stop;

  always_comb begin
    eposit_c = '0;
    body     = posit_i[6:0] ^ {7{posit_i[POSIT_W-1]}};
    run_len  = 4'd0;
    run_stop = 1'b0;
    // Regime run: identical bits starting at the MSB of the body.
    for (int i = 6; i >= 0; i--) begin
      if (!run_stop && (body[i] == body[6])) run_len = run_len + 4'd1;
      else                                    run_stop = 1'b1;
    end
    tail = body << (run_len + 4'd1);

    eposit_c[INF]  = (posit_i == 8'h80);
    eposit_c[ZERO] = (posit_i == 8'h00);
    eposit_c[SIGN] = posit_i[POSIT_W-1];
    eposit_c[REGIME_MSB:REGIME_LSB] = body[6] ? (run_len + 4'(REGIME_BIAS) - 4'd1)
                                              : (4'(REGIME_BIAS) - run_len);
    eposit_c[EXPFRAC_MSB:EXPFRAC_LSB] = tail[6:2];
  end

endmodule

// File: rtl/posit_decode_arbiter_8bit_grant.sv
// One-hot requester arbiter; round-robin from ptr when POSIT_DEC_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module posit_dec_grant
  import posit_dec_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant_c
);

  logic [IDW:0] slot;
  logic         found;

`ifndef POSIT_DEC_ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    slot    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef POSIT_DEC_ARB_RR_EN
      slot = (IDW+1)'(ptr) + (IDW+1)'(i);
      if (slot >= (IDW+1)'(NREQ)) slot = slot - (IDW+1)'(NREQ);
`else
      slot = (IDW+1)'(i);
`endif
      if (!found && req_valid[slot[IDW-1:0]]) begin
        grant_c[slot[IDW-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
    if (!enable) grant_c = '0;
  end

endmodule

// File: rtl/posit_decode_arbiter_8bit.sv
// Shares one 8-bit posit decoder among NREQ requesters through a capture/decode pipeline.
// POSIT_DEC_ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module posit_decode_arbiter_8bit
  import posit_dec_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*POSIT_W-1:0]   req_posit,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EPOSIT_W-1:0]       out_eposit,
  output logic [IDW-1:0]            out_id,
  output logic [1:0]                inflight
);

  logic               s1_valid_q, s1_valid_d;
  logic [POSIT_W-1:0] s1_posit_q, s1_posit_d;
  logic [IDW-1:0]     s1_id_q,    s1_id_d;
  logic               out_valid_q, out_valid_d;
  eposit_t            out_eposit_q, out_eposit_d;
  logic [IDW-1:0]     out_id_q,   out_id_d;
  logic [1:0]         inflight_q, inflight_d;
  logic [IDW-1:0]     ptr_cur;

  logic               s2_adv, s1_adv, grant_en, accept;
  logic [NREQ-1:0]    grant_c;
  logic [IDW-1:0]     win_id;
  logic [POSIT_W-1:0] win_posit;
  logic [EPOSIT_W-1:0] dec_eposit_c;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign grant_en = s1_adv & ~rst;
  assign accept   = |grant_c;

  posit_dec_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant (
    .req_valid (req_valid),
    .ptr       (ptr_cur),
    .enable    (grant_en),
    .grant_c   (grant_c)
  );

  decode_posit_8bit u_decode (
    .posit_i  (s1_posit_q),
    .eposit_c (dec_eposit_c)
  );

  // Winner index and posit from the one-hot grant.
  always_comb begin
    win_id    = '0;
    win_posit = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        win_id    = IDW'(i);
        win_posit = req_posit[POSIT_W*i +: POSIT_W];
      end
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_posit_d   = s1_posit_q;
    s1_id_d      = s1_id_q;
    out_valid_d  = out_valid_q;
    out_eposit_d = out_eposit_q;
    out_id_d     = out_id_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_eposit_d = eposit_t'(dec_eposit_c);
        out_id_d     = s1_id_q;
      end
    end
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_posit_d = win_posit;
        s1_id_d    = win_id;
      end
    end
    inflight_d = 2'(s1_valid_d) + 2'(out_valid_d);
  end

`ifdef POSIT_DEC_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Next search starts just past the last winner.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_posit_q   <= '0;
      s1_id_q      <= '0;
      out_valid_q  <= 1'b0;
      out_eposit_q <= '0;
      out_id_q     <= '0;
      inflight_q   <= 2'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_posit_q   <= s1_posit_d;
      s1_id_q      <= s1_id_d;
      out_valid_q  <= out_valid_d;
      out_eposit_q <= out_eposit_d;
      out_id_q     <= out_id_d;
      inflight_q   <= inflight_d;
    end
  end

  assign req_ready  = grant_c;
  assign out_valid  = out_valid_q;
  assign out_eposit = out_eposit_q;
  assign out_id     = out_id_q;
  assign inflight   = inflight_q;

endmodule
